// File: rtl/tdm_demux_1to4_pkg.sv
// Shared types and sizing helpers for the TDM receive demultiplexer.
package tdm_demux_1to4_pkg;

    // Framing state: hunting for a sync word, or locked to the frame.
    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam int unsigned DEF_WIDTH    = 4;
    localparam int unsigned DEF_CHANNELS = 4;

    // Slot counter width; a counter never collapses below one bit.
    function automatic int unsigned slot_width(input int unsigned channels);
        return (channels < 2) ? 1 : $clog2(channels);
    endfunction

endpackage

// File: rtl/tdm_demux_1to4_if.sv
// Serial slot stream in, per-channel holding registers and framing status out.
interface tdm_demux_1to4_if
    import tdm_demux_1to4_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned CHANNELS = DEF_CHANNELS
);
    logic                      in_valid;
    logic                      in_sync;
    logic [WIDTH-1:0]          in_data;
    logic [CHANNELS*WIDTH-1:0] out_data;
    logic [CHANNELS-1:0]       out_valid;
    logic                      frame_done;
    logic                      locked;
    logic                      sync_err;

    // Stream source / status consumer side.
    modport master (
        output in_valid, in_sync, in_data,
        input  out_data, out_valid, frame_done, locked, sync_err
    );

    // Demultiplexer side.
    modport slave (
        input  in_valid, in_sync, in_data,
        output out_data, out_valid, frame_done, locked, sync_err
    );
endinterface

// File: rtl/tdm_slot_counter.sv
// Frame slot counter: load-to-1 on a sync capture, otherwise wraps at CHANNELS-1.
module tdm_slot_counter
    import tdm_demux_1to4_pkg::*;
#(
    parameter int unsigned CHANNELS = DEF_CHANNELS,
    localparam int unsigned SW      = slot_width(CHANNELS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_one,
    input  logic          en,
    output logic [SW-1:0] slot
);
    localparam logic [SW-1:0] LAST_SLOT = SW'(CHANNELS - 1);

    // Load takes priority: a sync word always restarts the frame at slot 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot <= '0;
        end else if (load_one) begin
            slot <= SW'(1);
        end else if (en) begin
            slot <= (slot == LAST_SLOT) ? '0 : slot + SW'(1);
        end
    end
endmodule

// File: rtl/tdm_demux_1to4.sv
// TDM receive demultiplexer: routes each slot word to its channel register,
// tracks frame lock and flags framing violations.
module tdm_demux_1to4
    import tdm_demux_1to4_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned CHANNELS = DEF_CHANNELS
) (
    input logic             clk,
    input logic             rst,
    tdm_demux_1to4_if.slave bus
);
    localparam int unsigned   SW        = slot_width(CHANNELS);
    localparam logic [SW-1:0] LAST_SLOT = SW'(CHANNELS - 1);

    state_t                    state;
    state_t                    next_state;
    logic [SW-1:0]             slot;
    logic [SW-1:0]             wr_idx;
    logic                      capture;
    logic                      load_one;
    logic                      advance;
    logic                      err;
    logic                      last_word;

    logic [CHANNELS*WIDTH-1:0] data_q;
    logic [CHANNELS-1:0]       valid_q;
    logic                      frame_done_q;
    logic                      locked_q;
    logic                      sync_err_q;

    // Slot position within the current frame.
    tdm_slot_counter #(
        .CHANNELS (CHANNELS)
    ) u_slot_counter (
        .clk      (clk),
        .rst      (rst),
        .load_one (load_one),
        .en       (advance),
        .slot     (slot)
    );

    // Framing decision for the word on the bus this cycle.
    always_comb begin
        capture    = 1'b0;
        wr_idx     = '0;
        load_one   = 1'b0;
        advance    = 1'b0;
        err        = 1'b0;
        next_state = state;
        if (bus.in_valid) begin
            if (state == HUNT) begin
                if (bus.in_sync) begin
                    capture    = 1'b1;
                    load_one   = 1'b1;
                    next_state = LOCKED;
                end
            end else if (bus.in_sync) begin
                // Sync restarts the frame; arriving mid-frame it abandons the partial one.
                capture  = 1'b1;
                load_one = 1'b1;
                err      = (slot != '0);
            end else if (slot != '0) begin
                capture = 1'b1;
                wr_idx  = slot;
                advance = 1'b1;
            end else begin
                // Expected a sync word at slot 0: drop lock and rehunt.
                err        = 1'b1;
                next_state = HUNT;
            end
        end
    end

    // Any error reloads or unlocks, so reaching the last slot implies a clean frame.
    assign last_word = advance && (slot == LAST_SLOT);

    // State, channel registers and one-cycle status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= HUNT;
            locked_q     <= 1'b0;
            data_q       <= '0;
            valid_q      <= '0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            state        <= next_state;
            locked_q     <= (next_state == LOCKED);
            frame_done_q <= last_word;
            sync_err_q   <= err;
            for (int k = 0; k < int'(CHANNELS); k++) begin
                valid_q[k] <= capture && (wr_idx == SW'(k));
                if (capture && (wr_idx == SW'(k))) begin
                    data_q[k*WIDTH +: WIDTH] <= bus.in_data;
                end
            end
        end
    end

    assign bus.out_data   = data_q;
    assign bus.out_valid  = valid_q;
    assign bus.frame_done = frame_done_q;
    assign bus.locked     = locked_q;
    assign bus.sync_err   = sync_err_q;

endmodule

// File: tb/tb_tdm_demux_1to4.sv
// Directed-vector bench for the TDM receive demultiplexer (WIDTH=4, CHANNELS=4).
module tb_tdm_demux_1to4;
    localparam int unsigned WIDTH    = 4;
    localparam int unsigned CHANNELS = 4;

    typedef struct {
        logic        v;
        logic        s;
        logic [3:0]  d;
        logic [15:0] od;
        logic [3:0]  ov;
        logic        fd;
        logic        lk;
        logic        er;
    } vec_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    vec_t vecs[$];

    tdm_demux_1to4_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) bus ();

    tdm_demux_1to4 #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic check_all(input int idx, input logic [15:0] od, input logic [3:0] ov,
                             input logic fd, input logic lk, input logic er);
        check("out_data",   idx, 32'(bus.out_data),   32'(od));
        check("out_valid",  idx, 32'(bus.out_valid),  32'(ov));
        check("frame_done", idx, 32'(bus.frame_done), 32'(fd));
        check("locked",     idx, 32'(bus.locked),     32'(lk));
        check("sync_err",   idx, 32'(bus.sync_err),   32'(er));
    endtask

    task automatic add(input logic v, input logic s, input logic [3:0] d,
                       input logic [15:0] od, input logic [3:0] ov,
                       input logic fd, input logic lk, input logic er);
        vec_t t;
        t.v = v; t.s = s; t.d = d; t.od = od; t.ov = ov; t.fd = fd; t.lk = lk; t.er = er;
        vecs.push_back(t);
    endtask

    // Drive one cycle's inputs, clock it, sample just after the edge.
    task automatic drive(input logic v, input logic s, input logic [3:0] d);
        bus.in_valid = v;
        bus.in_sync  = s;
        bus.in_data  = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        bus.in_valid = 1'b0;
        bus.in_sync  = 1'b0;
        bus.in_data  = 4'h0;
        rst = 1'b1;

        //   v  s  d      out_data   ov       fd lk er
        // Basic frame A,3,5,9
        add(1, 1, 4'hA, 16'h000A, 4'b0001, 0, 1, 0);
        add(1, 0, 4'h3, 16'h003A, 4'b0010, 0, 1, 0);
        add(1, 0, 4'h5, 16'h053A, 4'b0100, 0, 1, 0);
        add(1, 0, 4'h9, 16'h953A, 4'b1000, 1, 1, 0);
        // Missing sync at slot 0, then words discarded while hunting
        add(1, 0, 4'h7, 16'h953A, 4'b0000, 0, 0, 1);
        add(1, 0, 4'h7, 16'h953A, 4'b0000, 0, 0, 0);
        add(1, 0, 4'h7, 16'h953A, 4'b0000, 0, 0, 0);
        // Reacquire with frame 1,2,3,4
        add(1, 1, 4'h1, 16'h9531, 4'b0001, 0, 1, 0);
        add(1, 0, 4'h2, 16'h9521, 4'b0010, 0, 1, 0);
        add(1, 0, 4'h3, 16'h9321, 4'b0100, 0, 1, 0);
        add(1, 0, 4'h4, 16'h4321, 4'b1000, 1, 1, 0);
        // Early sync abandons partial frame 1,2
        add(1, 1, 4'h1, 16'h4321, 4'b0001, 0, 1, 0);
        add(1, 0, 4'h2, 16'h4321, 4'b0010, 0, 1, 0);
        add(1, 1, 4'h8, 16'h4328, 4'b0001, 0, 1, 1);
        add(1, 0, 4'h6, 16'h4368, 4'b0010, 0, 1, 0);
        add(1, 0, 4'h5, 16'h4568, 4'b0100, 0, 1, 0);
        add(1, 0, 4'h4, 16'h4568, 4'b1000, 1, 1, 0);
        // Gapped frame A,3,5,9; idle sync/data must be ignored
        add(1, 1, 4'hA, 16'h456A, 4'b0001, 0, 1, 0);
        add(0, 1, 4'hF, 16'h456A, 4'b0000, 0, 1, 0);
        add(0, 0, 4'hF, 16'h456A, 4'b0000, 0, 1, 0);
        add(0, 1, 4'hF, 16'h456A, 4'b0000, 0, 1, 0);
        add(1, 0, 4'h3, 16'h453A, 4'b0010, 0, 1, 0);
        add(0, 1, 4'hF, 16'h453A, 4'b0000, 0, 1, 0);
        add(0, 1, 4'hF, 16'h453A, 4'b0000, 0, 1, 0);
        add(0, 0, 4'hF, 16'h453A, 4'b0000, 0, 1, 0);
        add(1, 0, 4'h5, 16'h453A, 4'b0100, 0, 1, 0);
        add(0, 0, 4'hF, 16'h453A, 4'b0000, 0, 1, 0);
        add(0, 1, 4'hF, 16'h453A, 4'b0000, 0, 1, 0);
        add(0, 0, 4'hF, 16'h453A, 4'b0000, 0, 1, 0);
        add(1, 0, 4'h9, 16'h953A, 4'b1000, 1, 1, 0);
        add(0, 0, 4'h0, 16'h953A, 4'b0000, 0, 1, 0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_all(-1, 16'h0000, 4'b0000, 0, 0, 0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].v, vecs[i].s, vecs[i].d);
            check_all(i, vecs[i].od, vecs[i].ov, vecs[i].fd, vecs[i].lk, vecs[i].er);
        end

        // Async reset mid-frame after slot 2 has been captured
        drive(1, 1, 4'h1);
        check_all(100, 16'h9531, 4'b0001, 0, 1, 0);
        drive(1, 0, 4'h2);
        check_all(101, 16'h9521, 4'b0010, 0, 1, 0);
        drive(1, 0, 4'h3);
        check_all(102, 16'h9321, 4'b0100, 0, 1, 0);
        #2;
        rst = 1'b1;
        #1;
        check_all(103, 16'h0000, 4'b0000, 0, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        // Post-reset word without sync is discarded in HUNT
        drive(1, 0, 4'h7);
        check_all(104, 16'h0000, 4'b0000, 0, 0, 0);
        drive(1, 1, 4'h5);
        check_all(105, 16'h0005, 4'b0001, 0, 1, 0);
        drive(0, 0, 4'h0);
        check_all(106, 16'h0005, 4'b0000, 0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
